// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and helpers for the pipelined CLA add/subtract unit
package cla_pkg;

    localparam int GROUP_W = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int ngroups(input int width);
        return width / GROUP_W;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - combinational 4-bit carry-lookahead group
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               ci,
    output logic [GROUP_W-1:0] s,
    output logic               co,
    output logic               c3,
    output logic               g,
    output logic               p
);

    logic [GROUP_W-1:0] gen;
    logic [GROUP_W-1:0] prop;
    logic               c1;
    logic               c2;

    always_comb begin
        gen  = a & b;
        prop = a ^ b;
        c1   = gen[0] | (prop[0] & ci);
        c2   = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & ci);
        c3   = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & ci);
        g    = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0]);
        p    = &prop;
        co   = g | (p & ci);
        s    = prop ^ {c3, c2, c1, ci};
    end

endmodule

// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined add/subtract, one 4-bit lookahead group per register stage
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             as,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NGROUPS = ngroups(WIDTH);
    localparam int LAST    = NGROUPS - 1;

    logic [NGROUPS-1:0] vld_q, vld_d;
    logic [NGROUPS-1:0] carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   a_q   [NGROUPS];
    logic [WIDTH-1:0]   a_d   [NGROUPS];
    logic [WIDTH-1:0]   b_q   [NGROUPS];
    logic [WIDTH-1:0]   b_d   [NGROUPS];
    logic [WIDTH-1:0]   res_q [NGROUPS];
    logic [WIDTH-1:0]   res_d [NGROUPS];

    // Stage k inputs: the external operands for stage 0, otherwise stage k-1's registers
    logic [NGROUPS-1:0] st_v;
    logic [NGROUPS-1:0] st_c;
    logic [WIDTH-1:0]   st_a [NGROUPS];
    logic [WIDTH-1:0]   st_b [NGROUPS];
    logic [WIDTH-1:0]   st_r [NGROUPS];

    logic [GROUP_W-1:0] grp_s [NGROUPS];
    logic [NGROUPS-1:0] grp_co;
    logic [NGROUPS-1:0] grp_c3;
    logic [NGROUPS-1:0] grp_g;
    logic [NGROUPS-1:0] grp_p;
    logic               unused_gp;
    logic               advance;

    assign advance   = !vld_q[LAST] || out_ready;
    assign unused_gp = ^{grp_g, grp_p};

    always_comb begin
        st_v    = '0;
        st_c    = '0;
        st_v[0] = in_valid;
        st_c[0] = (as == MODE_ADD) ? cin : ~cin;
        st_a[0] = in1;
        st_b[0] = in2 ^ {WIDTH{as == MODE_SUB}};
        st_r[0] = '0;
        for (int k = 1; k < NGROUPS; k++) begin
            st_v[k] = vld_q[k-1];
            st_c[k] = carry_q[k-1];
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_r[k] = res_q[k-1];
        end
    end

    for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
        cla_group4 u_grp (
            .a  (st_a[k][GROUP_W*k +: GROUP_W]),
            .b  (st_b[k][GROUP_W*k +: GROUP_W]),
            .ci (st_c[k]),
            .s  (grp_s[k]),
            .co (grp_co[k]),
            .c3 (grp_c3[k]),
            .g  (grp_g[k]),
            .p  (grp_p[k])
        );
    end

    // Every stage, empty or not, moves only when the output side can advance
    always_comb begin
        vld_d   = vld_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        for (int k = 0; k < NGROUPS; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            res_d[k] = res_q[k];
        end
        if (advance) begin
            vld_d   = st_v;
            carry_d = grp_co;
            ovf_d   = grp_c3[LAST] ^ grp_co[LAST];
            for (int k = 0; k < NGROUPS; k++) begin
                a_d[k]   = st_a[k];
                b_d[k]   = st_b[k];
                res_d[k] = st_r[k];
                res_d[k][GROUP_W*k +: GROUP_W] = grp_s[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < NGROUPS; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < NGROUPS; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                res_q[k] <= res_d[k];
            end
        end
    end

    assign in_ready  = advance;
    assign out_valid = vld_q[LAST];
    assign out       = res_q[LAST];
    assign cout      = carry_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = vld_q[LAST] && (res_q[LAST] == '0);

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - self-checking bench for cla_addsub_pipe
module tb_cla_addsub_pipe;

    localparam int NG = 4;

    typedef struct packed {
        logic [15:0] res;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic        as = 1'b0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out;
    logic        cout, ovf, zero;

    logic        v8_in_valid = 1'b0;
    logic        v8_in_ready;
    logic [7:0]  v8_in1 = '0;
    logic [7:0]  v8_in2 = '0;
    logic        v8_as = 1'b0;
    logic        v8_cin = 1'b0;
    logic        v8_out_valid;
    logic        v8_out_ready = 1'b1;
    logic [7:0]  v8_out;
    logic        v8_cout, v8_ovf, v8_zero;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    cla_addsub_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .as(as), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .cout(cout), .ovf(ovf), .zero(zero)
    );

    cla_addsub_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
        .in1(v8_in1), .in2(v8_in2), .as(v8_as), .cin(v8_cin),
        .out_valid(v8_out_valid), .out_ready(v8_out_ready), .out(v8_out),
        .cout(v8_cout), .ovf(v8_ovf), .zero(v8_zero)
    );

    // Integer-arithmetic reference: unsigned result/carry and signed range test for overflow
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic m, input logic c);
        exp_t   e;
        longint span, ua, ub, uc, sa, sb, sres, ures;
        span = longint'(1) << w;
        ua   = longint'(a);
        ub   = longint'(b);
        uc   = longint'(c);
        sa   = (ua >= span / 2) ? ua - span : ua;
        sb   = (ub >= span / 2) ? ub - span : ub;
        if (m == 1'b0) begin
            ures = ua + ub + uc;
            e.co = (ures >= span);
            sres = sa + sb + uc;
        end else begin
            ures = ua - ub - uc;
            e.co = (ua >= ub + uc);
            sres = sa - sb - uc;
        end
        ures  = ((ures % span) + span) % span;
        e.res = 16'(ures);
        e.ov  = (sres >= span / 2) || (sres < -(span / 2));
        e.z   = (ures == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic cycle();
        exp_t e;
        #1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(out_valid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb_out", 32'(out), 32'(e.res));
                chk("sb_cout", 32'(cout), 32'(e.co));
                chk("sb_ovf", 32'(ovf), 32'(e.ov));
                chk("sb_zero", 32'(zero), 32'(e.z));
            end
        end
        if (!rst && in_valid && in_ready)
            exp_q.push_back(model(16, in1, in2, as, cin));
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input logic [15:0] a, input logic [15:0] b, input logic m,
                              input logic c, input logic [15:0] e_out, input logic e_co,
                              input logic e_ov, input logic e_z);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in1 = a; in2 = b; as = m; cin = c;
        cycle();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            cycle();
            lat++;
        end
        chk("latency", 32'(lat), 32'(NG - 1));
        chk("dir_out", 32'(out), 32'(e_out));
        chk("dir_cout", 32'(cout), 32'(e_co));
        chk("dir_ovf", 32'(ovf), 32'(e_ov));
        chk("dir_zero", 32'(zero), 32'(e_z));
        cycle();
    endtask

    initial begin
        logic [15:0] first;
        int          lat;
        exp_t        e8;

        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out", 32'(out), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        chk("rst_zero", 32'(zero), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_v8_out_valid", 32'(v8_out_valid), 32'(0));

        run_single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_single(16'h7FFE, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_single(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_single(16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFE, 1'b1, 1'b0, 1'b0);

        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in1 = 16'($urandom); in2 = 16'($urandom);
            as = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid = 1'b0;
        chk("stall_first_valid", 32'(out_valid), 32'(1));
        first = out;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_in_ready", 32'(in_ready), 32'(0));
            chk("stall_out_stable", 32'(out), 32'(first));
            chk("stall_valid_held", 32'(out_valid), 32'(1));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("tput_valid", 32'(out_valid), 32'(1));
            cycle();
        end
        chk("stall_drained", 32'(out_valid), 32'(0));
        chk("stall_queue_empty", 32'(exp_q.size()), 32'(0));

        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in1 = 16'($urandom); in2 = 16'($urandom);
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("flush_out_valid", 32'(out_valid), 32'(0));
        chk("flush_out", 32'(out), 32'(0));
        chk("flush_in_ready", 32'(in_ready), 32'(1));
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("flush_no_stale", 32'(out_valid), 32'(0));
        end
        run_single(16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2234, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0: in1 = 16'h0000;
                1: in1 = 16'hFFFF;
                2: in1 = 16'h7FFF;
                3: in1 = 16'h8000;
                default: in1 = 16'($urandom);
            endcase
            in2 = ($urandom_range(0, 3) == 0) ? in1 : 16'($urandom);
            as  = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
        chk("random_drain_empty", 32'(exp_q.size()), 32'(0));

        v8_out_ready = 1'b1;
        v8_in_valid  = 1'b1;
        v8_in1 = 8'h80; v8_in2 = 8'h01; v8_as = 1'b1; v8_cin = 1'b0;
        #1;
        chk("w8_in_ready", 32'(v8_in_ready), 32'(1));
        @(posedge clk); #1;
        v8_in_valid = 1'b0;
        lat = 0;
        while (!v8_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e8 = model(8, 16'(8'h80), 16'(8'h01), 1'b1, 1'b0);
        chk("w8_latency", 32'(lat), 32'(1));
        chk("w8_out", 32'(v8_out), 32'(8'h7F));
        chk("w8_cout", 32'(v8_cout), 32'(1));
        chk("w8_ovf", 32'(v8_ovf), 32'(1));
        chk("w8_zero", 32'(v8_zero), 32'(0));
        chk("w8_model_out", 32'(v8_out), 32'(e8.res[7:0]));
        chk("w8_model_ovf", 32'(v8_ovf), 32'(e8.ov));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit built from 4-bit carry-lookahead groups, with one register stage per group.
- Generalises the 16-bit hierarchical CLA adder/subtractor to any width that is a multiple of 4.
- Adds carry-in/borrow-in chaining, signed-overflow and zero flags, and a valid/ready handshake with backpressure.
- Sits in the datapath between operand registers and the writeback/flag logic.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NGROUPS, WIDTH/4, derived; number of CLA groups, which equals the number of pipeline stages.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  pipeline can accept this cycle.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- as  input  1  mode: 0 = add, 1 = subtract.
- cin  input  1  add: carry-in; subtract: borrow-in (active high).
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result this cycle.
- out  output  WIDTH  sum or difference.
- cout  output  1  add: carry-out; subtract: 1 = no borrow, 0 = borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  out == 0.

Behaviour:
- Operand transform: B' = in2 XOR {WIDTH{as}}.
- Carry into group 0: c0 = as ? ~cin : cin.
- Result: A + B' + c0, taken mod 2^WIDTH; cout is bit WIDTH of that sum.
- Stage k (k = 0..NGROUPS-1) computes result bits [4k+3:4k] from the registered group-k operand bits and the carry registered by stage k-1 (c0 for k = 0).
- Stage k registers: remaining unprocessed operand groups, result groups completed so far, the carry out, and a valid bit.
- Latency: a transfer accepted on edge N (in_valid && in_ready) appears on out/out_valid after edge N+NGROUPS-1. For WIDTH=16 that is 4 registered stages, visible during the 4th cycle after acceptance.
- Throughput: one operation per cycle when out_ready is held high.
- Stall: advance = !out_valid || out_ready, and in_ready = advance.
  - When advance = 0, every stage holds; out and the flags stay stable.
  - No bubble collapse: all stages stall together, including empty ones.
- in_valid = 0 while advance = 1 injects a bubble (valid = 0), which propagates through the stages.
- ovf = carry into MSB XOR carry out of MSB. The final group supplies the internal carry into bit 3.
- zero is derived from the registered out; it is meaningful only while out_valid = 1.
- Output changes only on an advancing edge.
- Reset (synchronous): all stage valid bits 0, out = 0, cout = 0, ovf = 0, zero = 0, out_valid = 0.
  - In-flight operations are discarded.
  - in_ready = 1 from the cycle after the reset edge.
  - Reset has priority over advance.
- Simultaneous out_ready and in_valid with a full pipeline: the output retires and the new operation enters on the same edge; nothing is lost or duplicated.
- Data path bits are don't-care while their valid bit is 0, but they must not cause X on the flags once out_valid = 1.

Decomposition:
- Shared package `cla_pkg` holds:
  - GROUP_W = 4.
  - Mode constants MODE_ADD = 0, MODE_SUB = 1.
  - A function returning NGROUPS for a given WIDTH.
- One sub-module, `cla_group4`:
  - Purely combinational 4-bit lookahead group.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co, c3 (carry into bit 3), and group g and p.
  - Instantiated NGROUPS times, once per stage.

Test Plan:
- WIDTH=16, add, cin=0, 0xFFFF + 0x0001 → 4 cycles later: out=0x0000, cout=1, ovf=0, zero=1.
- WIDTH=16, add, cin=1, 0x7FFE + 0x0001 → out=0x8000, cout=0, ovf=1, zero=0.
- WIDTH=16, sub, cin=0, 0x0005 − 0x0007 → out=0xFFFE, cout=0 (borrow), ovf=0. Then sub, cin=1, 0x1000 − 0x0001 → out=0x0FFE, cout=1.
- WIDTH=16, four back-to-back operations, out_ready held low for 3 cycles after the first result:
  - in_ready is low during the hold.
  - out stays stable during the hold.
  - All four results appear in order with no loss; throughput is 1 per cycle after release.
- Operations in flight, rst asserted for 1 cycle → next cycle: out_valid=0, out=0. No stale result ever emerges. A new operation issued after reset completes correctly.
- WIDTH=8 instance, sub, cin=0, 0x80 − 0x01 → after 2 stages: out=0x7F, cout=1, ovf=1.
